frame_buffer_reader: RTL and testbench
======================================

Name: frame_buffer_reader

Overview:
- Scan-out engine: the transmit end of the GPU output stream.
- After a frame-buffer flip, it walks the front frame-buffer SRAM read port from address 0 to NUM_PIXELS-1.
- It packs COLOR_BITS pixels into 32-bit words and pushes them onto the data_out / data_ready_out interface, with back-pressure from write_buffer_full.
- Sits between the frame-buffer double SRAM (read channel 0) and the top-level output port.

Parameters:
- ADDR_SIZE, 10, frame-buffer read address width (FRAME_BUFFER_ADDR_SIZE in system).
- COLOR_BITS, 8, bits per pixel; must divide 32.
- NUM_PIXELS, 1024, pixels per frame (WIDTH*HEIGHT in system); must be ≤ 2^ADDR_SIZE.
- PPW (derived localparam), 32/COLOR_BITS, pixels per output word.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to send the current front buffer; ignored unless idle.
- fb_read_addr  out  ADDR_SIZE  frame-buffer SRAM read address.
- fb_data_in  in  COLOR_BITS  SRAM read data; valid one cycle after the address.
- data_out  out  32  packed pixel word.
- data_ready_out  out  1  word transfer strobe.
- write_buffer_full  in  1  downstream cannot accept a word this cycle.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse after the final word transfers.

Behaviour:
- One clock clk; reset rst is synchronous and active-high.
- Reset (any state, including mid-frame):
  - state goes to IDLE; pixel counter, capture counter and word register clear to 0.
  - fb_read_addr=0, data_out=0, data_ready_out=0, busy=0, done=0.
  - No done pulse is generated for an aborted frame.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 → FETCH next cycle.
  - Pixel counter and word register are cleared on entry to FETCH from IDLE.
- FETCH (one word's worth of pixels):
  - Issue n = min(PPW, NUM_PIXELS - pix) consecutive addresses, one per cycle. fb_read_addr is registered and equals the pixel counter.
  - Each returned pixel is captured the following cycle. Pixel k of the word goes to bits [k*COLOR_BITS +: COLOR_BITS], i.e. LSB-first.
  - Unfetched slots of a partial final word are 0.
  - FETCH lasts n+1 cycles, then → SEND.
- SEND:
  - data_out holds the word.
  - data_ready_out = !write_buffer_full (combinational qualification of the registered SEND state). A word transfers in exactly the cycle where data_ready_out=1.
  - While write_buffer_full=1 the state holds; data_out and fb_read_addr stay stable; no SRAM reads are issued.
  - On transfer: if pixels remain → FETCH (word register cleared); else → DONE.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
  - busy=0 in that IDLE cycle.
- start while busy (including during DONE) is ignored, not queued.
- Latency:
  - With start high in cycle 0 and full=0, the first data_ready_out is in cycle PPW+2.
  - Each full word takes PPW+2 cycles.
  - Words per frame = ceil(NUM_PIXELS/PPW).
- Address never exceeds NUM_PIXELS-1; there is no wrap.
- The pixel counter is ADDR_SIZE+1 bits wide so it can reach NUM_PIXELS without overflow.
- write_buffer_full toggling every cycle: each low cycle in SEND is exactly one transfer; never a duplicate, never a skip.

Decomposition:
- Shared package (defines_package) holds:
  - COLOR_BITS, FRAME_BUFFER_ADDR_SIZE, WIDTH, HEIGHT, and an output WORD_BITS=32 constant.
  - typedef enum fbr_state_t {IDLE, FETCH, SEND, DONE}.
- One natural sub-module: pixel_packer.
  - Inputs: clear, capture, slot index, pixel.
  - Output: 32-bit word assembled LSB-first.
- The FSM and address counter stay in frame_buffer_reader.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then idle 5 cycles → all outputs 0, busy=0, no reads issued.
- Basic frame (NUM_PIXELS=8, COLOR_BITS=8, SRAM[i]=i+1), start in cycle 0, full=0:
  - data_ready_out high in cycles 6 and 12.
  - data_out=32'h04030201 then 32'h08070605.
  - done pulse in cycle 13, busy low from cycle 14.
- Partial final word (NUM_PIXELS=10, SRAM[i]=8'hA0+i):
  - 3 words; last = 32'h0000A9A8.
  - Only addresses 0..9 ever appear on fb_read_addr.
- Back-pressure: hold write_buffer_full=1 for 7 cycles when first entering SEND:
  - data_ready_out=0 throughout; data_out and fb_read_addr stable.
  - Transfer occurs on the first cycle full=0; the word sequence is unchanged vs the basic frame.
- Toggling full (1,0,1,0...) across whole frame: exactly ceil(NUM_PIXELS/PPW) strobes; scoreboard matches SRAM contents; start pulses mid-frame are ignored.
- Reset mid-frame: assert rst during second FETCH:
  - Outputs return to 0 next cycle; no done.
  - A new start afterwards restarts from address 0 and produces the full frame.

Source files
------------

// File: rtl/frame_buffer_reader_pkg.sv
// frame_buffer_reader_pkg: shared scan-out constants and FSM state type.
package frame_buffer_reader_pkg;
    localparam int COLOR_BITS             = 8;
    localparam int FRAME_BUFFER_ADDR_SIZE = 10;
    localparam int WIDTH                  = 32;
    localparam int HEIGHT                 = 32;
    localparam int WORD_BITS              = 32;
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} fbr_state_t;
endpackage

// File: rtl/frame_buffer_reader_if.sv
// frame_buffer_reader_if: SRAM read port plus packed-word output stream.
interface frame_buffer_reader_if
    import frame_buffer_reader_pkg::*;
#(
    parameter int ADDR_SIZE  = frame_buffer_reader_pkg::FRAME_BUFFER_ADDR_SIZE,
    parameter int COLOR_BITS = frame_buffer_reader_pkg::COLOR_BITS
);
    logic [ADDR_SIZE-1:0]  fb_read_addr;
    logic [COLOR_BITS-1:0] fb_data_in;
    logic [WORD_BITS-1:0]  data_out;
    logic                  data_ready_out;
    logic                  write_buffer_full;
    modport master (
        output fb_read_addr, data_out, data_ready_out,
        input  fb_data_in, write_buffer_full
    );
    modport slave (
        input  fb_read_addr, data_out, data_ready_out,
        output fb_data_in, write_buffer_full
    );
endinterface

// File: rtl/frame_buffer_reader_pixel_packer.sv
// pixel_packer: assembles pixels LSB-first into one output word; clear wins over capture.
module pixel_packer
    import frame_buffer_reader_pkg::*;
#(
    parameter int COLOR_BITS = frame_buffer_reader_pkg::COLOR_BITS,
    parameter int SLOT_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  capture_i,
    input  logic [SLOT_W-1:0]     slot_i,
    input  logic [COLOR_BITS-1:0] pixel_i,
    output logic [WORD_BITS-1:0]  word_o
);
    localparam int PPW = WORD_BITS / COLOR_BITS;
    logic [WORD_BITS-1:0] word_q, word_d;
    always_comb begin
        word_d = word_q;
        for (int k = 0; k < PPW; k++)
            if (capture_i && slot_i == SLOT_W'(k)) word_d[k*COLOR_BITS +: COLOR_BITS] = pixel_i;
        if (clear_i) word_d = '0;
    end
    always_ff @(posedge clk)
        word_q <= rst ? '0 : word_d;
    assign word_o = word_q;
endmodule

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: walks the front frame buffer once per start and streams packed words
// downstream, stalling on write_buffer_full.
module frame_buffer_reader
    import frame_buffer_reader_pkg::*;
#(
    parameter int ADDR_SIZE  = frame_buffer_reader_pkg::FRAME_BUFFER_ADDR_SIZE,
    parameter int COLOR_BITS = frame_buffer_reader_pkg::COLOR_BITS,
    parameter int NUM_PIXELS = frame_buffer_reader_pkg::WIDTH * frame_buffer_reader_pkg::HEIGHT
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    frame_buffer_reader_if.master bus
);
    localparam int PPW = WORD_BITS / COLOR_BITS;
    localparam int SW  = $clog2(PPW + 1);
    localparam logic [ADDR_SIZE:0] NP    = (ADDR_SIZE + 1)'(NUM_PIXELS);
    localparam logic [SW-1:0]      PPW_S = SW'(PPW);
    fbr_state_t           state_q, state_d;
    logic [ADDR_SIZE:0]   pix_q, pix_d, pix_n;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [SW-1:0]        slot_q, slot_d, cap_slot;
    logic                 cap_q, cap_d;
    logic                 issue, xfer, clear;
    assign pix_n    = pix_q + 1'b1;
    assign cap_slot = slot_q - 1'b1;
    assign issue    = state_q == FETCH && slot_q < PPW_S && pix_q < NP;
    assign xfer     = state_q == SEND && !bus.write_buffer_full;
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        slot_d  = slot_q;
        cap_d   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = FETCH;
                pix_d   = '0;
                addr_d  = '0;
                slot_d  = '0;
                clear   = 1'b1;
            end
            FETCH: begin
                cap_d = issue;
                if (issue) begin
                    pix_d  = pix_n;
                    slot_d = slot_q + 1'b1;
                    // hold the last legal address rather than wrapping past the frame
                    addr_d = pix_n < NP ? pix_n[ADDR_SIZE-1:0] : addr_q;
                end else state_d = SEND;
            end
            SEND: if (xfer) begin
                clear   = 1'b1;
                slot_d  = '0;
                state_d = pix_q < NP ? FETCH : DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pix_q   <= '0;
            addr_q  <= '0;
            slot_q  <= '0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            slot_q  <= slot_d;
            cap_q   <= cap_d;
        end
    end
    pixel_packer #(.COLOR_BITS(COLOR_BITS), .SLOT_W(SW)) u_pack (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .capture_i (cap_q),
        .slot_i    (cap_slot),
        .pixel_i   (bus.fb_data_in),
        .word_o    (bus.data_out)
    );
    assign bus.fb_read_addr   = addr_q;
    assign bus.data_ready_out = xfer;
    assign busy_o             = state_q != IDLE;
    assign done_o             = state_q == DONE;
endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader: random and directed scan-out frames against a frame-level model.
module tb_frame_buffer_reader;
    localparam int AS = 4, CB = 8, NP = 10, PPW = 4, WORDS = 3;
    logic clk = 0, rst = 1, start = 0;
    logic busy, done;
    always #5 clk = ~clk;
    frame_buffer_reader_if #(.ADDR_SIZE(AS), .COLOR_BITS(CB)) bus();
    frame_buffer_reader #(.ADDR_SIZE(AS), .COLOR_BITS(CB), .NUM_PIXELS(NP)) dut (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done), .bus(bus)
    );
    logic [CB-1:0] sram [16];
    always @(posedge clk) bus.fb_data_in <= sram[bus.fb_read_addr];
    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    function automatic int nw(input int w);
        return (NP - w * PPW < PPW) ? NP - w * PPW : PPW;
    endfunction
    function automatic logic [31:0] wexp(input int w);
        logic [31:0] r = 0;
        for (int k = 0; k < PPW; k++)
            if (w * PPW + k < NP) r[k*CB +: CB] = sram[w*PPW + k];
        return r;
    endfunction
    function automatic int amin(input int a);
        return a < NP - 1 ? a : NP - 1;
    endfunction
    // frame-level model: phase 0 idle, 1 reading word m_w (cycle m_j), 2 offering word, 3 done
    int m_ph = 0, m_w = 0, m_j = 0, ns = 0;
    bit m_fresh = 1;
    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_fresh = 1;
        end else case (m_ph)
            0: if (start) begin m_ph = 1; m_w = 0; m_j = 0; m_fresh = 0; end
            1: if (m_j == nw(m_w)) m_ph = 2; else m_j++;
            2: if (!bus.write_buffer_full) begin
                m_w++;
                if (m_w * PPW < NP) begin m_ph = 1; m_j = 0; end else m_ph = 3;
            end
            default: m_ph = 0;
        endcase
    end
    always @(negedge clk) if (cyc > 0) begin
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("done", 32'(done), 32'(m_ph == 3));
        chk("ready", 32'(bus.data_ready_out), 32'(m_ph == 2 && !bus.write_buffer_full));
        chk("addr_range", 32'(bus.fb_read_addr < NP), 32'(1));
        if (m_ph == 1) chk("fetch_addr", 32'(bus.fb_read_addr), 32'(amin(m_w * PPW + m_j)));
        if (m_ph == 2) begin
            chk("send_addr", 32'(bus.fb_read_addr), 32'(amin(m_w * PPW + nw(m_w))));
            chk("word", bus.data_out, wexp(m_w));
        end
        if (m_ph == 0 && m_fresh) begin
            chk("idle_addr", 32'(bus.fb_read_addr), 32'(0));
            chk("idle_data", bus.data_out, 32'(0));
        end
        if (m_ph == 1 && m_w == 0 && m_j == 0) ns = 0;
        if (bus.data_ready_out) ns++;
        if (done) chk("strobes", 32'(ns), 32'(WORDS));
    end
    int lg_t[$];
    logic [31:0] lg_d[$];
    int t0, done_t, idle_t;
    task automatic begin_log();
        lg_t.delete(); lg_d.delete();
        t0 = -1; done_t = -1; idle_t = -1;
    endtask
    task automatic tick(input bit s, input bit f, input bit r);
        @(posedge clk);
        #1 start = s; bus.write_buffer_full = f; rst = r;
        if (s && t0 < 0) t0 = cyc;
        @(negedge clk);
        if (t0 >= 0) begin
            if (bus.data_ready_out) begin lg_t.push_back(cyc - t0); lg_d.push_back(bus.data_out); end
            if (done) done_t = cyc - t0;
            if (!busy && done_t >= 0 && idle_t < 0) idle_t = cyc - t0;
        end
    endtask
    initial begin
        bus.write_buffer_full = 0;
        for (int i = 0; i < 16; i++) sram[i] = 8'(i + 1);
        begin_log();
        tick(0, 0, 1); tick(0, 0, 1);
        repeat (5) tick(0, 0, 0);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_data", bus.data_out, 32'(0));
        // basic frame with a partial final word
        begin_log();
        tick(1, 0, 0);
        repeat (24) tick(0, 0, 0);
        chk("n_words", 32'(lg_t.size()), 32'(3));
        chk("t_w0", 32'(lg_t[0]), 32'(6));
        chk("d_w0", lg_d[0], 32'h04030201);
        chk("t_w1", 32'(lg_t[1]), 32'(12));
        chk("d_w1", lg_d[1], 32'h08070605);
        chk("t_w2", 32'(lg_t[2]), 32'(16));
        chk("d_w2", lg_d[2], 32'h00000A09);
        chk("t_done", 32'(done_t), 32'(17));
        chk("t_idle", 32'(idle_t), 32'(18));
        for (int i = 0; i < 16; i++) sram[i] = 8'(8'hA0 + i);
        begin_log();
        tick(1, 0, 0);
        repeat (24) tick(0, 0, 0);
        chk("p_w0", lg_d[0], 32'hA3A2A1A0);
        chk("p_w2", lg_d[2], 32'h0000A9A8);
        // back-pressure for seven cycles on the first word
        for (int i = 0; i < 16; i++) sram[i] = 8'(i + 1);
        begin_log();
        tick(1, 0, 0);
        for (int c = 1; c < 32; c++) tick(0, c >= 6 && c <= 12, 0);
        chk("bp_t0", 32'(lg_t[0]), 32'(13));
        chk("bp_d0", lg_d[0], 32'h04030201);
        chk("bp_d1", lg_d[1], 32'h08070605);
        chk("bp_t2", 32'(lg_t[2]), 32'(23));
        chk("bp_done", 32'(done_t), 32'(24));
        // alternating full with ignored mid-frame starts
        begin_log();
        tick(1, 1, 0);
        for (int c = 1; c < 50; c++) tick(c < 16 && c % 5 == 3, c % 2 == 0, 0);
        chk("tg_words", 32'(lg_d.size()), 32'(3));
        chk("tg_d2", lg_d[2], 32'h00000A09);
        // reset during the second word's fetch
        begin_log();
        tick(1, 0, 0);
        for (int c = 1; c < 8; c++) tick(0, 0, 0);
        tick(0, 0, 1);
        tick(0, 0, 0);
        chk("mr_busy", 32'(busy), 32'(0));
        chk("mr_data", bus.data_out, 32'(0));
        chk("mr_addr", 32'(bus.fb_read_addr), 32'(0));
        repeat (20) tick(0, 0, 0);
        chk("mr_nodone", 32'(done_t), 32'hFFFFFFFF);
        begin_log();
        tick(1, 0, 0);
        repeat (24) tick(0, 0, 0);
        chk("mr_words", 32'(lg_d.size()), 32'(3));
        chk("mr_d0", lg_d[0], 32'h04030201);
        // random traffic; the model checks every cycle
        for (int i = 0; i < 16; i++) sram[i] = 8'($urandom);
        repeat (3000) tick($urandom_range(9) == 0, 1'($urandom), $urandom_range(399) == 0);
        tick(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
